// File: rtl/ttc_param10.sv
// ttc_param10: NUM_CH-channel APB2 timer/counter with per-channel prescaler, match and level interrupts.
// Optional one-shot mode (CTRL[8]) is compiled in when TTC10_ONE_SHOT_EN is defined.
module ttc_param10 #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
) (
  input  logic              pclk10,
  input  logic              p_reset10,
  input  logic              psel10,
  input  logic              penable10,
  input  logic              pwrite10,
  input  logic [7:0]        paddr10,
  input  logic [31:0]       pwdata10,
  output logic [31:0]       prdata10,
  output logic [NUM_CH-1:0] interrupt10
);

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [NUM_CH-1:0] en_q, en_d, mode_q, mode_d, dir_q, dir_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d, mtc_q, mtc_d;
  logic [NUM_CH-1:0] ie_ovf_q, ie_ovf_d, ie_mtc_q, ie_mtc_d;
  logic [NUM_CH-1:0] irq_q, irq_d;
`ifdef TTC10_ONE_SHOT_EN
  logic [NUM_CH-1:0] os_q, os_d;
`endif
  logic [3:0]       ps_q   [NUM_CH];
  logic [3:0]       ps_d   [NUM_CH];
  logic [3:0]       pre_q  [NUM_CH];
  logic [3:0]       pre_d  [NUM_CH];
  logic [CNT_W-1:0] ival_q [NUM_CH];
  logic [CNT_W-1:0] ival_d [NUM_CH];
  logic [CNT_W-1:0] mtch_q [NUM_CH];
  logic [CNT_W-1:0] mtch_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q  [NUM_CH];
  logic [CNT_W-1:0] cnt_d  [NUM_CH];
  logic [31:0]      prdata_q, prdata_d;

  logic             wr_en, rd_en, sts_wr, ie_wr;
  logic             ch_hit, rst_pulse, tick, ovf_set, mtc_set;
  logic [CNT_W-1:0] nxt;
  logic             unused_bits;

  assign unused_bits = ^{pwdata10, paddr10};

  always_comb begin
    wr_en     = psel10 & penable10 & pwrite10;
    rd_en     = psel10 & ~penable10 & ~pwrite10;
    sts_wr    = wr_en && (paddr10[7:2] == 6'h3C);
    ie_wr     = wr_en && (paddr10[7:2] == 6'h3D);
    en_d      = en_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    ovf_d     = ovf_q;
    mtc_d     = mtc_q;
    ie_ovf_d  = ie_ovf_q;
    ie_mtc_d  = ie_mtc_q;
    irq_d     = irq_q;
`ifdef TTC10_ONE_SHOT_EN
    os_d      = os_q;
`endif
    ps_d      = ps_q;
    pre_d     = pre_q;
    ival_d    = ival_q;
    mtch_d    = mtch_q;
    cnt_d     = cnt_q;
    prdata_d  = rd_en ? 32'd0 : prdata_q;
    ch_hit    = 1'b0;
    rst_pulse = 1'b0;
    tick      = 1'b0;
    ovf_set   = 1'b0;
    mtc_set   = 1'b0;
    nxt       = '0;

    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit    = (paddr10[7:4] == 4'(c));
      rst_pulse = 1'b0;
      ovf_set   = 1'b0;
      mtc_set   = 1'b0;
      nxt       = cnt_q[c];

      if (wr_en && ch_hit) begin
        case (paddr10[3:2])
          2'd0: begin
            en_d[c]   = pwdata10[0];
            mode_d[c] = pwdata10[1];
            dir_d[c]  = pwdata10[2];
            ps_d[c]   = pwdata10[7:4];
            rst_pulse = pwdata10[3];
`ifdef TTC10_ONE_SHOT_EN
            os_d[c]   = pwdata10[8];
`endif
          end
          2'd1:    ival_d[c] = pwdata10[CNT_W-1:0];
          2'd2:    mtch_d[c] = pwdata10[CNT_W-1:0];
          default: ;
        endcase
      end

      // Tick on the cycle the prescaler reaches PS; >= covers PS being lowered mid-count.
      tick     = en_q[c] && (pre_q[c] >= ps_q[c]);
      pre_d[c] = (!en_q[c] || rst_pulse || tick) ? 4'd0 : pre_q[c] + 4'd1;

      if (rst_pulse) begin
        cnt_d[c] = pwdata10[2] ? (pwdata10[1] ? ival_q[c] : ONES) : '0;
      end else if (tick) begin
        if (!dir_q[c]) begin
          if (mode_q[c] ? (cnt_q[c] == ival_q[c]) : (cnt_q[c] == ONES)) begin
            nxt     = '0;
            ovf_set = 1'b1;
          end else begin
            nxt = cnt_q[c] + ONE;
          end
        end else begin
          if (cnt_q[c] == '0) begin
            nxt     = mode_q[c] ? ival_q[c] : ONES;
            ovf_set = 1'b1;
          end else begin
            nxt = cnt_q[c] - ONE;
          end
        end
        cnt_d[c] = nxt;
        mtc_set  = (nxt == mtch_q[c]);
`ifdef TTC10_ONE_SHOT_EN
        if (ovf_set && os_q[c]) en_d[c] = 1'b0;
`endif
      end

      // A hardware set in the same cycle as a W1C wins.
      ovf_d[c] = (ovf_q[c] & ~(sts_wr & pwdata10[c]))     | ovf_set;
      mtc_d[c] = (mtc_q[c] & ~(sts_wr & pwdata10[8 + c])) | mtc_set;
      if (ie_wr) begin
        ie_ovf_d[c] = pwdata10[c];
        ie_mtc_d[c] = pwdata10[8 + c];
      end
      irq_d[c] = (ovf_q[c] & ie_ovf_q[c]) | (mtc_q[c] & ie_mtc_q[c]);

      if (rd_en && ch_hit) begin
        case (paddr10[3:2])
          2'd0: begin
            prdata_d[0]   = en_q[c];
            prdata_d[1]   = mode_q[c];
            prdata_d[2]   = dir_q[c];
            prdata_d[7:4] = ps_q[c];
`ifdef TTC10_ONE_SHOT_EN
            prdata_d[8]   = os_q[c];
`endif
          end
          2'd1:    prdata_d = 32'(ival_q[c]);
          2'd2:    prdata_d = 32'(mtch_q[c]);
          default: prdata_d = 32'(cnt_q[c]);
        endcase
      end
      if (rd_en && paddr10[7:2] == 6'h3C) begin
        prdata_d[c]     = ovf_q[c];
        prdata_d[8 + c] = mtc_q[c];
      end
      if (rd_en && paddr10[7:2] == 6'h3D) begin
        prdata_d[c]     = ie_ovf_q[c];
        prdata_d[8 + c] = ie_mtc_q[c];
      end
    end
  end

  always_ff @(posedge pclk10) begin
    if (p_reset10) begin
      en_q     <= '0;
      mode_q   <= '0;
      dir_q    <= '0;
      ovf_q    <= '0;
      mtc_q    <= '0;
      ie_ovf_q <= '0;
      ie_mtc_q <= '0;
      irq_q    <= '0;
`ifdef TTC10_ONE_SHOT_EN
      os_q     <= '0;
`endif
      ps_q     <= '{default: '0};
      pre_q    <= '{default: '0};
      ival_q   <= '{default: '0};
      mtch_q   <= '{default: '0};
      cnt_q    <= '{default: '0};
      prdata_q <= '0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      ovf_q    <= ovf_d;
      mtc_q    <= mtc_d;
      ie_ovf_q <= ie_ovf_d;
      ie_mtc_q <= ie_mtc_d;
      irq_q    <= irq_d;
`ifdef TTC10_ONE_SHOT_EN
      os_q     <= os_d;
`endif
      ps_q     <= ps_d;
      pre_q    <= pre_d;
      ival_q   <= ival_d;
      mtch_q   <= mtch_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
    end
  end

  assign prdata10    = prdata_q;
  assign interrupt10 = irq_q;

endmodule

// File: tb/tb_ttc_param10.sv
// Self-checking bench for ttc_param10 (NUM_CH=3, CNT_W=16): register table plus timed counter sequences.
module tb_ttc_param10;

  logic        pclk10 = 1'b0;
  logic        p_reset10 = 1'b1;
  logic        psel10 = 1'b0, penable10 = 1'b0, pwrite10 = 1'b0;
  logic [7:0]  paddr10 = '0;
  logic [31:0] pwdata10 = '0;
  logic [31:0] prdata10;
  logic [2:0]  interrupt10;

  ttc_param10 #(.NUM_CH(3), .CNT_W(16)) dut (
    .pclk10(pclk10), .p_reset10(p_reset10), .psel10(psel10), .penable10(penable10),
    .pwrite10(pwrite10), .paddr10(paddr10), .pwdata10(pwdata10),
    .prdata10(prdata10), .interrupt10(interrupt10)
  );

  always #5 pclk10 = ~pclk10;

  int cyc = 0;
  always @(posedge pclk10) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { string name; logic [31:0] exp; } sb_t;
  sb_t sb_q[$];

  typedef struct { logic [7:0] addr; logic [31:0] wdata; logic [31:0] exp; string name; } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge pclk10); #1; end
  endtask

  // Write lands on the third edge after the call.
  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge pclk10); #1;
    psel10 = 1'b1; penable10 = 1'b0; pwrite10 = 1'b1; paddr10 = a; pwdata10 = d;
    @(posedge pclk10); #1;
    penable10 = 1'b1;
    @(posedge pclk10); #1;
    psel10 = 1'b0; penable10 = 1'b0; pwrite10 = 1'b0;
  endtask

  // Data reflects state after the edge following the call (setup ends on the second edge).
  task automatic check_read(input logic [7:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    sb_t got;
    logic [31:0] rd;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(posedge pclk10); #1;
    psel10 = 1'b1; penable10 = 1'b0; pwrite10 = 1'b0; paddr10 = a;
    @(posedge pclk10); #1;
    rd = prdata10;
    penable10 = 1'b1;
    @(posedge pclk10); #1;
    psel10 = 1'b0; penable10 = 1'b0;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty %s", name);
    end else begin
      got = sb_q.pop_front();
      chk(got.name, rd, got.exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, d, w2, d2, t;

    repeat (3) @(posedge pclk10);
    #1;
    chk("reset_irq", 32'(interrupt10), 32'd0);
    chk("reset_prdata", prdata10, 32'd0);
    p_reset10 = 1'b0;

    tbl[0] = '{8'h04, 32'hFFFF1234, 32'h0000_1234, "interval0_trunc"};
    tbl[1] = '{8'h18, 32'h0000ABCD, 32'h0000_ABCD, "match1"};
    tbl[2] = '{8'h28, 32'h00000005, 32'h0000_0005, "match2"};
    tbl[3] = '{8'hF4, 32'hFFFFFFFF, 32'h0000_0707, "int_en_mask"};
    tbl[4] = '{8'hF4, 32'h00000000, 32'h0000_0000, "int_en_clear"};
    tbl[5] = '{8'h30, 32'h0000FFFF, 32'h0000_0000, "ch3_write_ignored"};
    tbl[6] = '{8'h3C, 32'h00000001, 32'h0000_0000, "ch3_count_zero"};
    tbl[7] = '{8'hF8, 32'h00000001, 32'h0000_0000, "unmapped_zero"};
    tbl[8] = '{8'h0C, 32'h00000055, 32'h0000_0000, "count_ro"};
`ifdef TTC10_ONE_SHOT_EN
    tbl[9] = '{8'h00, 32'hFFFF01F0, 32'h0000_01F0, "ctrl_ps_oneshot"};
`else
    tbl[9] = '{8'h00, 32'hFFFF01F0, 32'h0000_00F0, "ctrl_ps_no_oneshot"};
`endif
    for (int i = 0; i < 10; i++) begin
      apb_wr(tbl[i].addr, tbl[i].wdata);
      check_read(tbl[i].addr, tbl[i].exp, tbl[i].name);
    end
    apb_wr(8'h00, 32'h08);
    check_read(8'h00, 32'h0, "ctrl_rst_reads0");

    // Ch0 up-interval, INTERVAL=4, PS=0, interrupt on OVF.
    apb_wr(8'hF4, 32'h1);
    apb_wr(8'h04, 32'h4);
    apb_wr(8'h00, 32'h3);
    w = cyc;
    for (int k = 1; k <= 7; k++) begin
      idle(1);
      chk($sformatf("ch0_irq_k%0d", k), 32'(interrupt10), (k >= 6) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      check_read(8'h0C, 32'((cyc + 1 - w) % 5), $sformatf("ch0_count_%0d", i));
      idle(i % 3);
    end
    apb_wr(8'h00, 32'h2);
    d = cyc;
    idle(3);
    check_read(8'h0C, 32'((d - w) % 5), "ch0_frozen");
    check_read(8'hF0, 32'h101, "ch0_status");
    apb_wr(8'hF0, 32'h1);
    chk("ch0_irq_before_drop", 32'(interrupt10), 32'd1);
    idle(1);
    chk("ch0_irq_after_w1c", 32'(interrupt10), 32'd0);
    check_read(8'hF0, 32'h100, "ch0_status_w1c");
    apb_wr(8'hF0, 32'h100);

    // Ch1 down free-run, PS=3, MATCH=0xFFFD.
    apb_wr(8'h18, 32'hFFFD);
    apb_wr(8'h10, 32'h3C);
    check_read(8'h1C, 32'hFFFF, "ch1_rst_load");
    check_read(8'h10, 32'h34, "ch1_ctrl");
    apb_wr(8'h10, 32'h35);
    w = cyc;
    for (int i = 0; i < 4; i++) begin
      check_read(8'h1C, 32'(65535 - (cyc + 1 - w) / 4), $sformatf("ch1_count_%0d", i));
      check_read(8'hF0, (((cyc + 1 - w) / 4) >= 2) ? 32'h200 : 32'h0, $sformatf("ch1_status_%0d", i));
      idle(i);
    end
    apb_wr(8'h10, 32'h34);
    apb_wr(8'hF0, 32'h200);

    // Ch2 freeze and resume in up free-run.
    apb_wr(8'h20, 32'h1);
    w = cyc;
    idle(7);
    apb_wr(8'h20, 32'h0);
    d = cyc;
    check_read(8'h2C, 32'(d - w), "ch2_frozen");
    apb_wr(8'h20, 32'h1);
    w2 = cyc;
    idle(3);
    apb_wr(8'h20, 32'h0);
    d2 = cyc;
    t = (d - w) + (d2 - w2);
    check_read(8'h2C, 32'(t), "ch2_resumed");

    // Ch2 down-interval loaded by EN+RST together.
    apb_wr(8'h24, 32'h5);
    apb_wr(8'h20, 32'h0F);
    w = cyc;
    check_read(8'h2C, 32'(5 - ((cyc + 1 - w) % 6)), "ch2_down_ival_0");
    check_read(8'h2C, 32'(5 - ((cyc + 1 - w) % 6)), "ch2_down_ival_1");

    // INTERVAL=0: OVF every tick, so a W1C in any cycle collides with a set.
    apb_wr(8'h24, 32'h0);
    apb_wr(8'h20, 32'h0B);
    idle(2);
    apb_wr(8'hF0, 32'h404);
    check_read(8'hF0, 32'h004, "set_beats_w1c");
    apb_wr(8'h20, 32'h02);
    apb_wr(8'hF0, 32'h404);
    check_read(8'hF0, 32'h0, "status_cleared");

`ifdef TTC10_ONE_SHOT_EN
    apb_wr(8'h04, 32'h2);
    apb_wr(8'h00, 32'h0A);
    apb_wr(8'h00, 32'h103);
    w = cyc;
    check_read(8'h0C, 32'h1, "oneshot_first");
    idle(3);
    check_read(8'h00, 32'h102, "oneshot_en_cleared");
    check_read(8'h0C, 32'h0, "oneshot_count_held");
    check_read(8'hF0, 32'h101, "oneshot_status");
    apb_wr(8'hF0, 32'h101);
`endif

    // Reset in the middle of counting and of an APB write.
    apb_wr(8'h04, 32'h4);
    apb_wr(8'h00, 32'h3);
    idle(8);
    check_read(8'h04, 32'h4, "pre_reset_interval");
    @(posedge pclk10); #1;
    psel10 = 1'b1; penable10 = 1'b0; pwrite10 = 1'b1; paddr10 = 8'h24; pwdata10 = 32'h77;
    @(posedge pclk10); #1;
    penable10 = 1'b1;
    p_reset10 = 1'b1;
    @(posedge pclk10); #1;
    chk("midreset_irq", 32'(interrupt10), 32'd0);
    chk("midreset_prdata", prdata10, 32'd0);
    p_reset10 = 1'b0;
    psel10 = 1'b0; penable10 = 1'b0; pwrite10 = 1'b0;
    check_read(8'h00, 32'h0, "midreset_ctrl0");
    check_read(8'h0C, 32'h0, "midreset_count0");
    check_read(8'h24, 32'h0, "midreset_write_dropped");
    check_read(8'hF4, 32'h0, "midreset_int_en");
    check_read(8'hF0, 32'h0, "midreset_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttc_param10.md
Name: ttc_param10

Overview:
Parametrised successor of the triple timer counter, an APB2 slave in the APB subsystem. It provides NUM_CH independent CNT_W-bit timer channels. Each channel has:
- a 4-bit prescaler
- up or down counting
- free-run or interval mode
- a match comparator

Per-channel status and enable registers produce one level interrupt per channel for the interrupt controller.

Parameters:
NUM_CH, 3, number of timer channels (legal 1..8).
CNT_W, 16, counter, interval and match width (legal 2..32).

Ports:
pclk10  input  1  system clock; all logic rises on this edge.
p_reset10  input  1  reset, synchronous and active-high.
psel10  input  1  APB select.
penable10  input  1  APB enable (access phase).
pwrite10  input  1  1 = write, 0 = read.
paddr10  input  8  byte address; bits [1:0] ignored.
pwdata10  input  32  write data.
prdata10  output  32  read data.
interrupt10  output  NUM_CH  per-channel interrupt, active-high level.

Behaviour:
- Reset: while p_reset10=1 at a pclk10 edge, all registers, counters, prescalers, prdata10 and interrupt10 go to 0.
- Register map, channel c at base c*0x10:
  - +0x0 CTRL (RW): [0] EN, [1] MODE (0 free-run, 1 interval), [2] DIR (0 up, 1 down), [3] RST (write-1 pulse, reads 0), [7:4] PS.
  - +0x4 INTERVAL (RW, CNT_W bits).
  - +0x8 MATCH (RW, CNT_W bits).
  - +0xC COUNT (RO, CNT_W bits).
- Global registers:
  - 0xF0 INT_STATUS: bit c = OVF(c), bit 8+c = MTC(c); write-1-to-clear.
  - 0xF4 INT_EN (RW): same bit layout.
- Unused bits read 0. Channels c >= NUM_CH and unmapped addresses read 0; writes to them are ignored.
- APB write: registers update at the edge ending the access phase (psel10 & penable10 & pwrite10). No wait states.
- APB read: prdata10 is registered at the edge ending the setup phase (psel10 & !penable10 & !pwrite10). It is valid throughout the access phase and held until the next read setup.
- Prescaler:
  - While EN=1, the prescaler produces a tick every PS+1 pclk10 cycles. PS=0 gives a tick every cycle.
  - The prescaler is held at 0 while EN=0 or on an RST write.
  - The first tick arrives PS+1 cycles after EN is written to 1.
- Counting, applied at the tick edge:
  - Up, free-run: all-ones -> 0 raises OVF; otherwise increment.
  - Up, interval: COUNT==INTERVAL -> 0 raises OVF (period INTERVAL+1 ticks); otherwise increment.
  - Down, free-run: 0 -> all-ones raises OVF; otherwise decrement.
  - Down, interval: 0 -> INTERVAL raises OVF; otherwise decrement.
- Boundary cases:
  - INTERVAL=0 in interval mode: OVF on every tick.
  - INTERVAL written while running takes effect on the next comparison.
  - COUNT > INTERVAL when up-interval starts: the counter runs to all-ones, wraps, then obeys INTERVAL.
- Match: MTC(c) is set at a tick edge whose new COUNT equals MATCH.
- Status set/clear:
  - Status bits are set at the same edge as the counter update.
  - A set and a W1C of the same bit in the same cycle: set wins.
- RST write:
  - COUNT loads 0 for up counting, INTERVAL for down-interval, all-ones for down-free-run.
  - If CTRL is written with EN=1 and RST=1 together, the count loads and counting starts from the loaded value.
- Clearing EN freezes COUNT. Re-enabling resumes from the frozen value.
- interrupt10[c]: registered; equals |(INT_STATUS & INT_EN) for channel c bits, one cycle after the status bit is set.
- Reset mid-operation: everything returns to reset values at that edge, including any APB transfer in flight (that write is dropped).

Optional Feature:
Macro TTC10_ONE_SHOT_EN.
- Defined:
  - CTRL[8] is the ONESHOT bit (RW).
  - When ONESHOT=1 and OVF is raised, hardware clears EN at that same edge. COUNT holds the post-wrap/reload value.
- Undefined: CTRL[8] reads 0, writes are ignored, and counting is always continuous.

Test Plan:
- Reset: assert p_reset10 with mid-count EN=1 -> next cycle all registers 0, interrupt10=0, prdata10=0.
- Ch0 up-interval, INTERVAL=4, PS=0, INT_EN bit0=1 -> COUNT sequence 1,2,3,4,0; OVF set at the wrap edge; interrupt10[0]=1 one cycle later; W1C of 0x1 to 0xF0 -> interrupt10[0] drops 1 cycle after the clear.
- Ch1 down free-run, PS=3, RST then EN -> COUNT all-ones; decrements every 4 cycles; MATCH=0xFFFD sets MTC bit 9 on the second tick.
- Simultaneous: OVF event in the same cycle as W1C of that bit -> bit stays 1.
- APB: read 0x2C -> ch2 COUNT in the access phase; read 0x3C with NUM_CH=3 -> 0; write to 0x30 -> no effect.
- TTC10_ONE_SHOT_EN defined, ONESHOT=1, up-interval INTERVAL=2 -> counts 1,2,0, then EN reads 0 and COUNT stays 0.
